// File: rtl/spi_fifo_pkg.sv
// Shared constants and helpers for the Quad-SPI receive/transmit FIFOs.
// Optional error flags are enabled by defining SPI_FIFO_ERR_FLAGS_EN.
package spi_fifo_pkg;

    localparam int RX_DATA_W = 8;
    localparam int RX_DEPTH  = 261;
    localparam int TX_DATA_W = 8;
    localparam int TX_DEPTH  = 261;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Depth need not be a power of two, so wrap explicitly.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/spi_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, no reset.
// Optional error flags are enabled by defining SPI_FIFO_ERR_FLAGS_EN.
module spi_fifo_mem
    import spi_fifo_pkg::*;
#(
    parameter int DATA_W = RX_DATA_W,
    parameter int DEPTH  = RX_DEPTH,
    parameter int PTR_W  = clog2(RX_DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_fifo_sync.sv
// Show-ahead single-clock FIFO with almost flags, flush and fill count.
// Define SPI_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module spi_fifo_sync
    import spi_fifo_pkg::*;
#(
    parameter int DATA_W    = RX_DATA_W,
    parameter int DEPTH     = RX_DEPTH,
    parameter int AE_THRESH = 1,
    parameter int AF_THRESH = 260,
    localparam int PTR_W    = clog2(DEPTH),
    localparam int CNT_W    = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              almost_empty,
    output logic              full,
    output logic              almost_full,
    output logic [CNT_W-1:0]  count
`ifdef SPI_FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] AE_LVL  = CNT_W'(AE_THRESH);
    localparam logic [CNT_W-1:0] AF_LVL  = CNT_W'(AF_THRESH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q, ae_q, full_q, af_q;
    logic             writing, reading, mem_we;

    always_comb begin
        writing  = wr_en & (~full_q | rd_en);
        reading  = rd_en & ~empty_q;
        mem_we   = writing & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (writing) begin
                wr_ptr_d = PTR_W'(ptr_inc(int'(wr_ptr_q), DEPTH));
            end
            if (reading) begin
                rd_ptr_d = PTR_W'(ptr_inc(int'(rd_ptr_q), DEPTH));
            end
            case ({writing, reading})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Flags come from the next count so they line up with count itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            ae_q     <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= (cnt_d == '0);
            ae_q     <= (cnt_d <= AE_LVL);
            full_q   <= (cnt_d == CNT_MAX);
            af_q     <= (cnt_d >= AF_LVL);
        end
    end

    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign count        = cnt_q;

`ifdef SPI_FIFO_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en & full_q & ~rd_en) begin
                ovf_q <= 1'b1;
            end
            if (rd_en & empty_q) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`endif

    spi_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_out)
    );

endmodule

// File: doc/spi_fifo_sync.md
# spi_fifo_sync

Parametrised single-clock FIFO for the Quad-SPI core, sitting between the SPI shift engine and the bus-side register interface in both the receive and transmit paths. Generalises the fixed 8-bit / 261-entry receive FIFO to arbitrary width and depth. Adds threshold-based almost flags, a synchronous flush and an exact fill count. Read data is show-ahead: the head word is always present on `data_out` while not empty.

## Interface
Parameters:
- `DATA_W`, 8, word width in bits (≥1)
- `DEPTH`, 261, number of entries (≥2, need not be a power of two)
- `AE_THRESH`, 1, `almost_empty` asserted while count ≤ AE_THRESH (0 ≤ AE_THRESH < DEPTH)
- `AF_THRESH`, 260, `almost_full` asserted while count ≥ AF_THRESH (0 < AF_THRESH ≤ DEPTH)
- Derived: `PTR_W` = clog2(DEPTH); `CNT_W` = clog2(DEPTH+1)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous clear of pointers, count and flags
- `wr_en`  in  1  write request
- `data_in`  in  DATA_W  write data
- `rd_en`  in  1  read (pop) request
- `data_out`  out  DATA_W  head-of-FIFO word, combinational from memory
- `empty`, `almost_empty`, `full`, `almost_full`  out  1 each  registered status
- `count`  out  CNT_W  registered fill level, 0..DEPTH
- `overflow`, `underflow`  out  1 each  sticky error flags (only with macro, see Configuration)

## Operation
- `writing` = wr_en & (!full | rd_en); `reading` = rd_en & !empty.
- Write stores `data_in` at wr_ptr; the pointer increments and wraps DEPTH-1 → 0.
- Read advances rd_ptr with the same wrap rule. Memory contents are not altered by the read.
- count: +1 on writing only, −1 on reading only, unchanged on both or neither.
- Full with wr_en & rd_en: both occur, count stays DEPTH.
- Empty with wr_en & rd_en: write only, no bypass, count → 1.
- Write to full without rd_en: dropped. Read from empty: ignored; `data_out` is don't-care.
- All flags are computed from the next count and registered:
  - empty = (count==0)
  - full = (count==DEPTH)
  - almost_empty = (count≤AE_THRESH)
  - almost_full = (count≥AF_THRESH)
- Priority: reset_n low > flush > read/write.
- Flush zeroes both pointers and count and sets the flags to their reset values. wr_en and rd_en in the flush cycle are ignored. Memory is not cleared.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0. `data_out` is undefined until the first write.
- Reset asserted mid-transfer: the state clears immediately (asynchronous). Partially filled contents are lost.

## Timing
- Write at edge N: count, empty and the almost flags update at edge N. The written word is on `data_out` after N if the FIFO was empty.
- Read: the consumer samples `data_out` while rd_en=1. At the edge, rd_ptr advances and the next word (or don't-care if now empty) appears combinationally.
- Zero-latency read (show-ahead); write-to-read latency is one edge.
- Release of `reset_n` takes effect asynchronously. The first write is accepted on the first rising edge with reset_n high.

## Configuration
- `SPI_FIFO_ERR_FLAGS_EN` defined:
  - `overflow` ports are present and `overflow` sets on wr_en & full & !rd_en.
  - `underflow` ports are present and `underflow` sets on rd_en & empty.
  - Both flags are sticky, cleared only by reset or flush.
- Not defined: both ports are absent and no error logic is generated. All other behaviour is identical.

## Structure
- Shared package `spi_fifo_pkg`:
  - clog2 function
  - default DATA_W/DEPTH constants for the receive and transmit instances (8/261)
  - pointer increment-with-wrap function, parameterised by DEPTH
- Sub-module `spi_fifo_mem`: DEPTH×DATA_W storage with synchronous write and asynchronous read, no reset. The top level holds pointers, count and flags.

## Test plan
- Reset, then 261 writes of 0x00..0x04 (mod 256), no reads → count=261, full=1, almost_full=1 from count 260. A 262nd write is dropped; with the macro, overflow=1.
- Drain all 261 → `data_out` sequence 0x00..0x04 in order. empty=1 after the last read, almost_empty=1 at count≤1. A further rd_en leaves count=0; with the macro, underflow=1.
- Fill to full, then wr_en=rd_en=1 for 300 cycles with incrementing data → count stays 261 and read order is preserved across pointer wrap.
- Empty FIFO, wr_en=rd_en=1 with data 0xA5 → count=1, empty=0, data_out=0xA5 next cycle.
- Count=100, then assert flush with wr_en=1 → count=0, empty=1, flags and error bits cleared; the write is ignored.
- Assert reset_n low between clock edges mid-fill → flags reach their reset values without waiting for a clock edge. Repeat with DATA_W=32, DEPTH=16, AE=4, AF=12: the threshold flags toggle at counts 4/5 and 11/12.
